// File: rtl/cus_tag_cfg_ctrl.sv
// Shadow/live configuration controller for the custom-tag parser: software writes a shadow copy,
// and a commit publishes it atomically at a packet boundary after a short drain.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no commit pending, live outputs stable
// S_WAIT  | commit requested, waiting for the current packet to end
// S_DRAIN | at a boundary with ingress held, letting the parser pipeline empty
// S_APPLY | copy shadow into the live buses this cycle
module cus_tag_cfg_ctrl #(
    parameter int AXIS_ID_WIDTH     = 4,
    parameter int MAX_TAG_SIZE_BITS = 64,
    parameter int DRAIN_CYCLES      = 2,
    localparam int NUM_AXIS_ID      = 2**AXIS_ID_WIDTH,
    localparam int PER_ID           = 2*MAX_TAG_SIZE_BITS+1,
    localparam int REG_ADDR_WIDTH   = AXIS_ID_WIDTH+4
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          cfg_wr_en,
    input  logic [REG_ADDR_WIDTH-1:0]     cfg_wr_addr,
    input  logic [31:0]                   cfg_wr_data,
    input  logic [REG_ADDR_WIDTH-1:0]     cfg_rd_addr,
    output logic [31:0]                   cfg_rd_data,
    input  logic                          commit_req,
    output logic                          commit_busy,
    output logic                          commit_done,
    input  logic                          mon_tvalid,
    input  logic                          mon_tready,
    input  logic                          mon_tlast,
    output logic                          ingress_hold,
    output logic [15:0]                   cus_tag_config_regs,
    output logic [PER_ID*NUM_AXIS_ID-1:0] cus_tag_cam_values
);

    localparam bit WIDE = (MAX_TAG_SIZE_BITS == 64);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN, S_APPLY} state_t;

    state_t                   state;
    logic [7:0]               drain_cnt;
    logic                     in_packet;

    logic [63:0]              sh_tag  [NUM_AXIS_ID];
    logic [63:0]              sh_mask [NUM_AXIS_ID];
    logic [NUM_AXIS_ID-1:0]   sh_valid;
    logic [15:0]              sh_ether;

    logic                     wr_global;
    logic [AXIS_ID_WIDTH-1:0] wr_id;
    logic [2:0]               wr_word;
    logic                     rd_global;
    logic [AXIS_ID_WIDTH-1:0] rd_id;
    logic [2:0]               rd_word;
    logic [31:0]              rd_next;

    assign wr_global = cfg_wr_addr[REG_ADDR_WIDTH-1];
    assign wr_id     = cfg_wr_addr[REG_ADDR_WIDTH-2:3];
    assign wr_word   = cfg_wr_addr[2:0];
    assign rd_global = cfg_rd_addr[REG_ADDR_WIDTH-1];
    assign rd_id     = cfg_rd_addr[REG_ADDR_WIDTH-2:3];
    assign rd_word   = cfg_rd_addr[2:0];

    always_comb begin
        rd_next = 32'h0;
        if (rd_global) begin
            if (cfg_rd_addr[REG_ADDR_WIDTH-2:0] == '0)
                rd_next = {16'h0, sh_ether};
        end else begin
            case (rd_word)
                3'd0: rd_next = sh_tag[rd_id][31:0];
                3'd1: if (WIDE) rd_next = sh_tag[rd_id][63:32];
                3'd2: rd_next = sh_mask[rd_id][31:0];
                3'd3: if (WIDE) rd_next = sh_mask[rd_id][63:32];
                3'd4: rd_next = {31'h0, sh_valid[rd_id]};
                default: rd_next = 32'h0;
            endcase
        end
    end

    // Read samples the pre-write shadow, so a same-cycle write/read returns the old word.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_AXIS_ID; i++) begin
                sh_tag[i]  <= '0;
                sh_mask[i] <= '0;
            end
            sh_valid    <= '0;
            sh_ether    <= '0;
            cfg_rd_data <= '0;
        end else begin
            cfg_rd_data <= rd_next;
            if (cfg_wr_en) begin
                if (wr_global) begin
                    if (cfg_wr_addr[REG_ADDR_WIDTH-2:0] == '0)
                        sh_ether <= cfg_wr_data[15:0];
                end else begin
                    case (wr_word)
                        3'd0: sh_tag[wr_id][31:0] <= cfg_wr_data;
                        3'd1: if (WIDE) sh_tag[wr_id][63:32] <= cfg_wr_data;
                        3'd2: sh_mask[wr_id][31:0] <= cfg_wr_data;
                        3'd3: if (WIDE) sh_mask[wr_id][63:32] <= cfg_wr_data;
                        3'd4: sh_valid[wr_id] <= cfg_wr_data[0];
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn)
            in_packet <= 1'b0;
        else if (mon_tvalid && mon_tready)
            in_packet <= !mon_tlast;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state               <= S_IDLE;
            drain_cnt           <= '0;
            commit_busy         <= 1'b0;
            commit_done         <= 1'b0;
            cus_tag_config_regs <= '0;
            cus_tag_cam_values  <= '0;
        end else begin
            commit_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (commit_req) begin
                        state       <= S_WAIT;
                        commit_busy <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (!in_packet) begin
                        drain_cnt <= 8'(DRAIN_CYCLES);
                        state     <= (DRAIN_CYCLES == 0) ? S_APPLY : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= drain_cnt - 8'd1;
                    if (drain_cnt <= 8'd1)
                        state <= S_APPLY;
                end
                S_APPLY: begin
                    cus_tag_config_regs <= sh_ether;
                    for (int j = 0; j < NUM_AXIS_ID; j++)
                        cus_tag_cam_values[PER_ID*j +: PER_ID] <=
                            {sh_valid[j], sh_mask[j][MAX_TAG_SIZE_BITS-1:0], sh_tag[j][MAX_TAG_SIZE_BITS-1:0]};
                    commit_done <= 1'b1;
                    commit_busy <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Combinational so a new packet cannot start in the cycle the FSM reaches a boundary.
    assign ingress_hold = (state != S_IDLE) && !in_packet;

endmodule
